// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the byte-enabled data memory.
// Each access runs IDLE -> ACCESS -> RESP: grant, a single DM cycle, then the response.
//
// state  | meaning
// IDLE   | wait for a request, pick a winner, latch it, pulse gnt
// ACCESS | drive the one DM cycle (suppressed on error), capture Dout for loads
// RESP   | pulse done/err for the latched port, present rdata
module dm_arbiter #(
  parameter int DM_BYTES = 8192,
  parameter int ADDR_W   = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  input  logic              sext0,
  input  logic              sext1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [31:0]       Addr,
  output logic [3:0]        BE,
  output logic [31:0]       Din,
  input  logic [31:0]       Dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                last_q;
  logic                port_q, we_q, sext_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [31:0]         wdata_q, rd_q;

  logic                any_req, sel;
  logic                sel_we, sel_sext, sel_err;
  logic [ADDR_W-1:0]   sel_addr;
  logic [1:0]          sel_size;
  logic [31:0]         sel_wdata;
  logic [31:0]         addr32, rd_shift;

  // On a tie the port not granted last wins.
  assign any_req   = req0 | req1;
  assign sel       = (req0 & req1) ? ~last_q : req1;
  assign sel_we    = sel ? we1    : we0;
  assign sel_addr  = sel ? addr1  : addr0;
  assign sel_size  = sel ? size1  : size0;
  assign sel_sext  = sel ? sext1  : sext0;
  assign sel_wdata = sel ? wdata1 : wdata0;
  assign sel_err   = (sel_size == 2'd3)
                   | ((sel_size == 2'd1) & sel_addr[0])
                   | ((sel_size == 2'd2) & (sel_addr[1:0] != 2'b00))
                   | (sel_addr >= ADDR_W'(DM_BYTES));

  assign addr32   = 32'(addr_q);
  assign rd_shift = rd_q >> {addr_q[1:0], 3'b000};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wdata_q <= 32'd0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && any_req) begin
        last_q  <= sel;
        port_q  <= sel;
        we_q    <= sel_we;
        sext_q  <= sel_sext;
        err_q   <= sel_err;
        addr_q  <= sel_addr;
        size_q  <= sel_size;
        wdata_q <= sel_wdata;
      end
      if (state_q == S_ACCESS && !we_q && !err_q) begin
        rd_q <= Dout;
      end
    end
  end

  // Outputs are forced low while Reset is high so a reset during ACCESS never writes the DM.
  always_comb begin
    state_d  = state_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    err0     = 1'b0;
    err1     = 1'b0;
    rdata    = 32'd0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    Addr     = 32'd0;
    BE       = 4'b0000;
    Din      = 32'd0;
    if (!Reset) begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt0    = ~sel;
            gnt1    = sel;
            state_d = S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!err_q) begin
            MemWrite = we_q;
            MemRead  = ~we_q;
            Addr     = {addr32[31:2], 2'b00};
            case (size_q)
              2'd0: begin
                BE  = 4'b0001 << addr_q[1:0];
                Din = {4{wdata_q[7:0]}};
              end
              2'd1: begin
                BE  = addr_q[1] ? 4'b1100 : 4'b0011;
                Din = {2{wdata_q[15:0]}};
              end
              default: begin
                BE  = 4'b1111;
                Din = wdata_q;
              end
            endcase
          end
          state_d = S_RESP;
        end
        S_RESP: begin
          done0 = ~port_q;
          done1 = port_q;
          err0  = ~port_q & err_q;
          err1  = port_q & err_q;
          if (!we_q && !err_q) begin
            case (size_q)
              2'd0:    rdata = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
              2'd1:    rdata = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
              default: rdata = rd_q;
            endcase
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: behavioural DM, byte-level reference memory, directed and random accesses.
module tb_dm_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req0, req1, we0, we1, sext0, sext1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata, Addr, Din, Dout;
  logic        MemWrite, MemRead;
  logic [3:0]  BE;

  int total = 0;
  int bad   = 0;

  logic [31:0] dm [0:2047];
  logic        dm_clr;
  logic [7:0]  ref_mem [0:8191];
  int          last_gnt;

  dm_arbiter #(.DM_BYTES(8192), .ADDR_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .size0(size0), .size1(size1),
    .sext0(sext0), .sext1(sext1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .MemWrite(MemWrite), .MemRead(MemRead), .Addr(Addr), .BE(BE),
    .Din(Din), .Dout(Dout)
  );

  always #5 Clk = ~Clk;

  // Behavioural DM: byte-enabled write at the clock edge, combinational read.
  assign Dout = dm[Addr[12:2]];
  always @(posedge Clk) begin
    if (dm_clr) begin
      for (int i = 0; i < 2048; i++) dm[i] <= 32'd0;
    end else if (MemWrite) begin
      for (int b = 0; b < 4; b++)
        if (BE[b]) dm[Addr[12:2]][8*b +: 8] <= Din[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = 1 << sz;
    if (sz == 2'd3) return 1'b1;
    if (a >= 32'd8192) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit sx);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic drive_port(input int p, input bit we, input logic [31:0] a,
                            input logic [1:0] sz, input bit sx, input logic [31:0] wd);
    if (p == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; size0 = sz; sext0 = sx; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; size1 = sz; sext1 = sx; wdata1 = wd;
    end
  endtask

  // One complete access on a single port; entered and left just after a rising edge.
  task automatic access1(input int p, input bit we, input logic [31:0] a,
                         input logic [1:0] sz, input bit sx, input logic [31:0] wd);
    bit e;
    int n;
    logic [3:0]  ebe;
    logic [31:0] edin, erd;
    e    = model_err(a, sz);
    n    = 1 << sz;
    ebe  = 4'b0000;
    edin = 32'd0;
    if (!e) begin
      for (int i = 0; i < n; i++) ebe[(a % 4) + i] = 1'b1;
      for (int j = 0; j < 4; j++) edin[8*j +: 8] = wd[8*(j % n) +: 8];
    end
    erd = (!e && !we) ? model_load(a, sz, sx) : 32'd0;
    drive_port(p, we, a, sz, sx, wd);
    @(negedge Clk);
    chk("gnt0", 32'(gnt0), 32'(p == 0));
    chk("gnt1", 32'(gnt1), 32'(p == 1));
    last_gnt = p;
    @(posedge Clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge Clk);
    chk("acc_memwrite", 32'(MemWrite), 32'(!e && we));
    chk("acc_memread", 32'(MemRead), 32'(!e && !we));
    chk("acc_be", 32'(BE), 32'(ebe));
    if (!e) chk("acc_addr", Addr, a & 32'hFFFF_FFFC);
    if (!e && we) chk("acc_din", Din, edin);
    chk("acc_gnt", 32'({gnt1, gnt0}), 32'd0);
    @(posedge Clk); #1;
    if (!e && we) for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
    @(negedge Clk);
    chk("done0", 32'(done0), 32'(p == 0));
    chk("done1", 32'(done1), 32'(p == 1));
    chk("err", 32'({err1, err0}), p == 0 ? 32'(e) : 32'({e, 1'b0}));
    chk("rdata", rdata, erd);
    chk("resp_mem", 32'({MemWrite, MemRead}), 32'd0);
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    last_gnt = 1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    int          rp, w;
    logic [31:0] exp_a [0:1];
    logic [1:0]  exp_s [0:1];
    Reset = 1'b1; dm_clr = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; sext0 = 0; sext1 = 0;
    addr0 = 0; addr1 = 0; size0 = 0; size1 = 0; wdata0 = 0; wdata1 = 0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'd0;
    last_gnt = 1;
    repeat (2) @(posedge Clk);
    #1 dm_clr = 1'b0;
    req0 = 1'b1;
    @(negedge Clk);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_done", 32'({done1, done0, err1, err0}), 32'd0);
    chk("rst_mem", 32'({MemWrite, MemRead, BE}), 32'd0);
    chk("rst_addr", Addr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    req0 = 1'b0;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    chk("idle_out", 32'({gnt1, gnt0, done1, done0, MemWrite, MemRead, BE}), 32'd0);
    chk("idle_din", Din, 32'd0);
    @(posedge Clk); #1;

    access1(0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF);
    access1(0, 0, 32'h10, 2'd2, 0, 32'h0);
    access1(0, 1, 32'h13, 2'd0, 0, 32'h80);
    access1(1, 0, 32'h13, 2'd0, 1, 32'h0);
    access1(0, 0, 32'h13, 2'd0, 0, 32'h0);
    access1(1, 1, 32'h22, 2'd1, 0, 32'h1234);
    access1(0, 0, 32'h22, 2'd1, 1, 32'h0);
    access1(1, 1, 32'h30, 2'd1, 0, 32'hBEEF);
    access1(0, 0, 32'h30, 2'd1, 1, 32'h0);
    access1(1, 1, 32'h1FFC, 2'd2, 0, 32'hA5A5_0F0F);
    access1(0, 0, 32'h1FFF, 2'd0, 1, 32'h0);

    access1(0, 0, 32'h6, 2'd2, 0, 32'h0);
    access1(1, 1, 32'h5, 2'd1, 0, 32'hFFFF);
    access1(0, 0, 32'h2000, 2'd2, 0, 32'h0);
    access1(1, 1, 32'h14, 2'd3, 0, 32'h12345678);
    access1(0, 1, 32'h2004, 2'd0, 0, 32'h77);
    access1(0, 0, 32'h4, 2'd2, 0, 32'h0);
    access1(1, 0, 32'h14, 2'd2, 0, 32'h0);

    // Both ports held: grants must alternate starting with port 0 after reset.
    do_reset();
    exp_a[0] = 32'h10; exp_s[0] = 2'd2;
    exp_a[1] = 32'h13; exp_s[1] = 2'd0;
    drive_port(0, 0, exp_a[0], exp_s[0], 0, 32'h0);
    drive_port(1, 0, exp_a[1], exp_s[1], 1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      w = (last_gnt == 1) ? 0 : 1;
      last_gnt = w;
      @(negedge Clk);
      chk("rr_gnt0", 32'(gnt0), 32'(w == 0));
      chk("rr_gnt1", 32'(gnt1), 32'(w == 1));
      @(posedge Clk); #1;
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge Clk);
      chk("rr_acc_addr", Addr, exp_a[w] & 32'hFFFF_FFFC);
      chk("rr_acc_gnt", 32'({gnt1, gnt0}), 32'd0);
      @(posedge Clk);
      @(negedge Clk);
      chk("rr_done", 32'({done1, done0}), w == 0 ? 32'd1 : 32'd2);
      chk("rr_rdata", rdata, model_load(exp_a[w], exp_s[w], w == 1));
      @(posedge Clk); #1;
    end

    // Reset during the ACCESS cycle of a store must suppress the write and the done.
    access1(0, 1, 32'h40, 2'd2, 0, 32'h11223344);
    drive_port(0, 1, 32'h40, 2'd2, 0, 32'hCAFEF00D);
    @(negedge Clk);
    chk("rstacc_gnt", 32'(gnt0), 32'd1);
    @(posedge Clk); #1;
    req0 = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    chk("rstacc_memwrite", 32'(MemWrite), 32'd0);
    @(posedge Clk); #1 Reset = 1'b0;
    last_gnt = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("rstacc_nodone", 32'({done1, done0}), 32'd0);
    end
    @(posedge Clk); #1;
    access1(1, 0, 32'h40, 2'd2, 0, 32'h0);

    // Reset while a store request is pending in IDLE.
    drive_port(0, 1, 32'h40, 2'd2, 0, 32'h55AA55AA);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rstidle_gnt", 32'({gnt1, gnt0}), 32'd0);
    @(posedge Clk); #1;
    req0 = 1'b0; Reset = 1'b0;
    last_gnt = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("rstidle_nowrite", 32'({MemWrite, gnt0}), 32'd0);
    end
    @(posedge Clk); #1;
    access1(0, 0, 32'h40, 2'd2, 0, 32'h0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) ra = 32'd8184 + 32'($urandom_range(0, 15));
      else ra = 32'($urandom_range(0, 127));
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && rs == 2'd3) rs = 2'd2;
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
      rp = int'($urandom_range(0, 1));
      access1(rp, 1'($urandom_range(0, 1)), ra, rs, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-enabled data memory (DM).
- Port 0 serves the CPU MEM stage. Port 1 serves the debug/DMA loader.
- Per access it arbitrates round-robin, checks alignment and range, generates BE and lane-replicated write data, drives one DM cycle, and returns aligned, sign- or zero-extended read data.

Parameters:
- DM_BYTES, 8192, DM capacity in bytes; any address >= DM_BYTES is an error.
- ADDR_W, 32, request address width.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- req0, req1  in  1  request; held high until gnt
- we0, we1  in  1  1 = store, 0 = load
- addr0, addr1  in  ADDR_W  byte address
- size0, size1  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- sext0, sext1  in  1  load sign-extend enable
- wdata0, wdata1  in  32  store data, right-justified
- gnt0, gnt1  out  1  one-cycle pulse: request latched
- done0, done1  out  1  one-cycle pulse: access complete
- err0, err1  out  1  valid with done: misaligned, out of range, or reserved size
- rdata  out  32  load result, valid with done (shared between ports)
- MemWrite  out  1  to DM
- MemRead  out  1  to DM
- Addr  out  32  to DM, word-aligned (bits [1:0] = 0)
- BE  out  4  to DM
- Din  out  32  to DM
- Dout  in  32  from DM, combinational read

Behaviour:
- FSM states IDLE, ACCESS, RESP. Every access takes exactly 3 cycles; there is no pipelining.
- IDLE:
  - Any req high: select a winner, latch its we/addr/size/sext/wdata and port id, pulse that port's gnt, go to ACCESS.
  - Both high: grant the port not granted last. The last-grant pointer resets to 1, so port 0 wins the first tie.
  - The loser keeps req high and is granted in the next IDLE.
- Error check, computed at latch time:
  - size 3;
  - size 1 with addr[0] = 1;
  - size 2 with addr[1:0] != 0;
  - addr >= DM_BYTES.
- ACCESS:
  - No error: MemRead = ~we and MemWrite = we for this one cycle.
  - Addr = {latched addr[31:2], 2'b00}.
  - BE: byte -> 4'b0001 << addr[1:0]; half -> addr[1] ? 4'b1100 : 4'b0011; word -> 4'b1111.
  - Din: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
  - The DM write commits at the ACCESS-ending edge. For loads, Dout is captured into an internal register at that same edge.
  - Error: MemWrite, MemRead and BE stay 0. The DM is untouched.
  - Always go to RESP.
- RESP:
  - Pulse done for the latched port. err = error flag.
  - rdata, load without error:
    - byte: lane addr[1:0], extended per sext (bit 7 if sext = 1, else zeros);
    - half: lane addr[1], extended per sext (bit 15 if sext = 1, else zeros);
    - word: as read.
  - rdata = 0 for stores and for errors.
  - Return to IDLE. A new req can be granted the following cycle.
- Idle and reset outputs: gnt*, done*, err*, MemWrite, MemRead, BE = 0; Addr, Din, rdata = 0.
- Reset mid-operation:
  - FSM goes to IDLE and the latched request is discarded.
  - A write latched but not yet in ACCESS is never issued.
  - No done is produced.
  - Last-grant pointer returns to 1.
- A req deasserted before gnt is simply not served. A req held after done is treated as a new request.

Test Plan:
- Reset, then port 0 word store addr 0x10, wdata 0xDEADBEEF -> gnt0 in cycle 1; ACCESS with BE = 1111, Addr = 0x10, MemWrite = 1; done0 with err0 = 0 in cycle 3. Then word load 0x10 -> rdata = 0xDEADBEEF.
- Byte store 0x13 with wdata 0x80 -> BE = 1000, Din = 0x80808080. Then byte load 0x13 with sext = 1 -> 0xFFFFFF80; with sext = 0 -> 0x00000080.
- Half store 0x22 with wdata 0x1234 -> BE = 1100. Half load 0x22 with sext = 1 -> 0x00001234.
- req0 and req1 held together for 4 accesses -> grants alternate 0, 1, 0, 1, each 3 cycles apart, and each done is on the correct port.
- Word load at 0x6, half store at 0x5, word load at 0x2000 (DM_BYTES), and size 3 -> MemWrite = MemRead = 0 throughout; done with err = 1; rdata = 0; DM contents unchanged.
- Reset asserted in the ACCESS cycle of a store to 0x40 -> no done pulse; word 0x40 reads back its prior value. Reset asserted while the FSM is in IDLE with a store to 0x40 pending (before gnt) -> no gnt, no write.
